icache_dm: RTL and testbench

Direct-mapped, one-word-per-block instruction cache. It is the responder on the icache side of the datapath/cache interface, serving `imemREN`/`imemaddr` with `ihit`/`imemload`. On a miss it fetches the word from the memory controller over a `iREN`/`iaddr`/`iwait`/`iload` request port. It sits between the pipelined datapath's fetch stage and the memory/cache controller, with 32-bit hit and miss counters for performance reporting.

---
 rtl/icache_dm.sv | 124 ++++++++++++
 tb/tb_icache_dm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame read-only instruction cache with hit/miss counters.
// Latency: hits are combinational (0 cycles); a miss returns ihit N+2 cycles after the request (N = iwait cycles).
// Backpressure: iwait holds the fill in FETCH with iREN/iaddr stable; datapath requests are ignored until the fill lands.
module icache_dm #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } frame_t;

  frame_t          frames [SETS];
  state_t          state, state_nxt;
  logic [31:0]     miss_addr;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   miss_tag;
  logic [IW-1:0]   miss_idx;
  logic            hit;
  logic            miss_take;
  logic            fill_done;
  logic            unused_bits;

  assign req_tag     = imemaddr[31:IW+2];
  assign req_idx     = imemaddr[IW+1:2];
  assign miss_tag    = miss_addr[31:IW+2];
  assign miss_idx    = miss_addr[IW+1:2];
  assign unused_bits = ^imemaddr[1:0];

  assign hit = frames[req_idx].valid && (frames[req_idx].tag == req_tag);

  // Next-state and output decode; FETCH ignores the datapath entirely.
  always_comb begin
    state_nxt = state;
    ihit      = 1'b0;
    imemload  = 32'd0;
    iREN      = 1'b0;
    iaddr     = 32'd0;
    miss_take = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN && hit) begin
          ihit     = 1'b1;
          imemload = frames[req_idx].data;
        end
        if (imemREN && !hit) begin
          miss_take = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and latched miss address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'd0;
    end else begin
      state <= state_nxt;
      if (miss_take) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
      end
    end
  end

  // Frame array: cleared on reset, overwritten on the accepting fill edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        frames[i] <= '0;
      end
    end else if (fill_done) begin
      frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
    end
  end

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (ihit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_take) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  icache_dm #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e_ihit, input logic [31:0] e_load,
                         input logic e_iren, input logic [31:0] e_iaddr,
                         input logic [31:0] e_hc, input logic [31:0] e_mc);
    chk({name, ".ihit"}, {31'd0, ihit}, {31'd0, e_ihit});
    chk({name, ".imemload"}, imemload, e_load);
    chk({name, ".iREN"}, {31'd0, iREN}, {31'd0, e_iren});
    chk({name, ".iaddr"}, iaddr, e_iaddr);
    chk({name, ".hit_cnt"}, hit_cnt, e_hc);
    chk({name, ".miss_cnt"}, miss_cnt, e_mc);
  endtask

  task automatic add(input string n, input logic ren, input logic [31:0] addr, input logic wt,
                     input logic [31:0] ld, input logic eh, input logic [31:0] el,
                     input logic er, input logic [31:0] ea, input logic [31:0] hc,
                     input logic [31:0] mc);
    vec_t v;
    v.name = n; v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
    v.e_ihit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea; v.e_hc = hc; v.e_mc = mc;
    vecs.push_back(v);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // One entry per clock cycle: inputs driven at the falling edge, outputs checked 1ns later.
    //    name           ren  addr          wt  iload         ihit imemload      iREN iaddr        hc  mc
    add("cold_detect",   1, 32'h44,  1, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add("cold_wait1",    1, 32'h44,  1, 32'h0,        0, 32'h0,        1, 32'h44,  0, 1);
    add("cold_wait2",    1, 32'h44,  1, 32'h0,        0, 32'h0,        1, 32'h44,  0, 1);
    add("cold_wait3",    1, 32'h44,  1, 32'h0,        0, 32'h0,        1, 32'h44,  0, 1);
    add("cold_accept",   1, 32'h44,  0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h44,  0, 1);
    add("cold_hit",      1, 32'h44,  0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,   0, 1);
    add("byteoff_hit1",  1, 32'h47,  0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,   1, 1);
    add("byteoff_hit2",  1, 32'h47,  0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,   2, 1);
    add("noreq_1",       0, 32'h47,  0, 32'h0,        0, 32'h0,        0, 32'h0,   3, 1);
    add("noreq_2",       0, 32'h47,  0, 32'h0,        0, 32'h0,        0, 32'h0,   3, 1);
    add("conf84_detect", 1, 32'h84,  0, 32'h0,        0, 32'h0,        0, 32'h0,   3, 1);
    add("conf84_fill",   1, 32'h84,  0, 32'h11112222, 0, 32'h0,        1, 32'h84,  3, 2);
    add("conf84_hit",    1, 32'h84,  0, 32'h0,        1, 32'h11112222, 0, 32'h0,   3, 2);
    add("conf44_detect", 1, 32'h44,  0, 32'h0,        0, 32'h0,        0, 32'h0,   4, 2);
    add("conf44_fill",   1, 32'h44,  0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h44,  4, 3);
    add("conf44_hit",    1, 32'h44,  0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,   4, 3);
    add("sq_detect",     1, 32'h100, 1, 32'h0,        0, 32'h0,        0, 32'h0,   5, 3);
    add("sq_wait1",      1, 32'h200, 1, 32'h0,        0, 32'h0,        1, 32'h100, 5, 4);
    add("sq_wait2",      1, 32'h200, 1, 32'h0,        0, 32'h0,        1, 32'h100, 5, 4);
    add("sq_accept",     1, 32'h200, 0, 32'hCAFE0100, 0, 32'h0,        1, 32'h100, 5, 4);
    add("b2b_detect200", 1, 32'h200, 0, 32'h0,        0, 32'h0,        0, 32'h0,   5, 4);
    add("b2b_fill200",   1, 32'h200, 0, 32'h0200AAAA, 0, 32'h0,        1, 32'h200, 5, 5);
    add("b2b_hit200",    1, 32'h200, 0, 32'h0,        1, 32'h0200AAAA, 0, 32'h0,   5, 5);
    add("evict100",      1, 32'h100, 0, 32'h0,        0, 32'h0,        0, 32'h0,   6, 5);
    add("refill100",     1, 32'h100, 0, 32'hCAFE0100, 0, 32'h0,        1, 32'h100, 6, 6);
    add("hit100",        1, 32'h100, 0, 32'h0,        1, 32'hCAFE0100, 0, 32'h0,   6, 6);
    add("noreq_miss1",   0, 32'h300, 0, 32'h0,        0, 32'h0,        0, 32'h0,   7, 6);
    add("noreq_miss2",   0, 32'h300, 0, 32'h0,        0, 32'h0,        0, 32'h0,   7, 6);

    // Reset held, then released with no requests for 5 cycles.
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b0; iload = 32'h0;
    #12;
    chk_all("in_reset", 0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      chk_all($sformatf("idle%0d", i), 0, 32'h0, 0, 32'h0, 0, 0);
    end

    foreach (vecs[i]) begin
      @(negedge CLK);
      imemREN = vecs[i].ren; imemaddr = vecs[i].addr; iwait = vecs[i].wt; iload = vecs[i].ld;
      #1;
      chk_all(vecs[i].name, vecs[i].e_ihit, vecs[i].e_load, vecs[i].e_iren,
              vecs[i].e_iaddr, vecs[i].e_hc, vecs[i].e_mc);
    end

    // Reset asserted mid-FETCH drops the request at once and installs nothing.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1; iload = 32'h33333333;
    @(negedge CLK);
    #1;
    chk_all("rst_mid_fetch_pre", 0, 32'h0, 1, 32'h300, 7, 7);
    nRST = 1'b0;
    #1;
    chk_all("rst_mid_fetch_drop", 0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1; iwait = 1'b0;
    #1;
    chk_all("rst_after_remiss", 0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge CLK);
    #1;
    chk_all("rst_after_fetch", 0, 32'h0, 1, 32'h300, 0, 1);
    @(negedge CLK);
    #1;
    chk_all("rst_after_hit", 1, 32'h33333333, 0, 32'h0, 0, 1);
    // Earlier fills were wiped by reset.
    @(negedge CLK);
    imemaddr = 32'h44;
    #1;
    chk_all("rst_cleared_44", 0, 32'h0, 0, 32'h0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
